// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues base-RAM reads, and offers
// one instruction per cycle to IF/ID with a single-entry skid buffer for ID stalls.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctl_id_allow_in_i,
  input  logic        ctl_jbr_taken_i,
  input  logic [31:0] jbr_target_i,
  input  logic        ctl_baseram_hazard_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        ctl_if_over_o
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  st;
  logic [31:0] pc_r;
  logic        pend_r;
  logic [31:0] pend_pc_r;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  logic        redir;
  logic        fire;
  logic        running;

  // Offer side: the skid buffer wins over the response arriving this cycle
  always_comb begin
    if_pc_o   = 32'h0;
    if_inst_o = 32'h0;
    if (hold_v) begin
      if_pc_o   = hold_pc;
      if_inst_o = hold_inst;
    end else if (pend_r) begin
      if_pc_o   = pend_pc_r;
      if_inst_o = inst_rdata_i;
    end
  end

  assign ctl_if_over_o = hold_v | pend_r;
  assign running       = (st == ST_RUN);
  assign redir         = ctl_jbr_taken_i & ctl_id_allow_in_i;
  assign fire          = ctl_if_over_o & ctl_id_allow_in_i & ~redir;

  // A new read only issues when the slot it will land in is guaranteed free
  assign inst_req_o  = running & ~ctl_baseram_hazard_i & ~redir & (~ctl_if_over_o | fire);
  assign inst_addr_o = running ? pc_r : 32'h0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st        <= ST_BOOT;
      pc_r      <= RESET_PC;
      pend_r    <= 1'b0;
      pend_pc_r <= 32'h0;
      hold_v    <= 1'b0;
      hold_pc   <= 32'h0;
      hold_inst <= 32'h0;
    end else begin
      st <= ST_RUN;
      if (redir) begin
        // Wrong-path work, in flight or buffered, is dropped
        pc_r   <= {jbr_target_i[31:2], 2'b00};
        pend_r <= 1'b0;
        hold_v <= 1'b0;
      end else begin
        if (inst_req_o) begin
          pend_pc_r <= pc_r;
          pc_r      <= pc_r + 32'd4;
          pend_r    <= 1'b1;
        end else begin
          pend_r <= 1'b0;
        end
        if (pend_r && !fire) begin
          hold_v    <= 1'b1;
          hold_pc   <= pend_pc_r;
          hold_inst <= inst_rdata_i;
        end else if (hold_v && fire) begin
          hold_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a small base-RAM model plus queues of expected
// request addresses and expected consumed PCs.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        allow;
  logic        jbr;
  logic [31:0] tgt;
  logic        haz;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] rdata = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_over;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_fire[$];

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .ctl_id_allow_in_i   (allow),
    .ctl_jbr_taken_i     (jbr),
    .jbr_target_i        (tgt),
    .ctl_baseram_hazard_i(haz),
    .inst_req_o          (inst_req),
    .inst_addr_o         (inst_addr),
    .inst_rdata_i        (rdata),
    .if_pc_o             (if_pc),
    .if_inst_o           (if_inst),
    .ctl_if_over_o       (if_over)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Base RAM: one-cycle read latency, garbage when no read was issued
  always @(posedge clk) rdata <= inst_req ? mem(inst_addr) : 32'h0BAD_F00D;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"},  32'(inst_req),  32'h0);
    chk({tag, "_addr"}, inst_addr,      32'h0);
    chk({tag, "_pc"},   if_pc,          32'h0);
    chk({tag, "_inst"}, if_inst,        32'h0);
    chk({tag, "_over"}, 32'(if_over),   32'h0);
  endtask

  // One clock of stimulus; requests and consumptions are matched against the queues
  task automatic cyc(input logic a, input logic j, input logic [31:0] t, input logic h);
    logic        fire;
    logic [31:0] e;
    @(negedge clk);
    allow = a; jbr = j; tgt = t; haz = h;
    #1;
    if (inst_req) begin
      chk("req_expected", 32'(exp_req.size() > 0), 32'h1);
      if (exp_req.size() > 0) begin
        e = exp_req.pop_front();
        chk("req_addr", inst_addr, e);
      end
    end
    fire = if_over & a & ~(j & a);
    if (fire) begin
      chk("fire_expected", 32'(exp_fire.size() > 0), 32'h1);
      if (exp_fire.size() > 0) begin
        e = exp_fire.pop_front();
        chk("fire_pc", if_pc, e);
        chk("fire_inst", if_inst, mem(e));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; allow = 1'b0; jbr = 1'b0; tgt = 32'h0; haz = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_zero_outputs("reset");

    exp_req  = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008,
                 32'h8000_1000, 32'h8000_1004, 32'h8000_1008, 32'h8000_100C,
                 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    exp_fire = '{32'h8000_0000, 32'h8000_0004,
                 32'h8000_1000, 32'h8000_1004, 32'h8000_1008,
                 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    rst_n = 1'b1; allow = 1'b1;
    #1 chk_zero_outputs("boot");

    // Streaming start
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // ID stalls three cycles with 8000_0004 in flight
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("stall_over", 32'(if_over), 32'h1);
      chk("stall_pc", if_pc, 32'h8000_0004);
      chk("stall_inst", if_inst, mem(32'h8000_0004));
      chk("stall_req", 32'(inst_req), 32'h0);
    end
    cyc(1, 0, 0, 0);
    // Buffer 8000_0008, then redirect flushes it
    cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h8000_1002, 0);
    chk("redir_req", 32'(inst_req), 32'h0);
    cyc(1, 0, 0, 0);
    chk("after_redir_over", 32'(if_over), 32'h0);
    cyc(1, 0, 0, 0);
    // Two-cycle hazard
    cyc(1, 0, 0, 1);
    chk("haz1_req", 32'(inst_req), 32'h0);
    cyc(1, 0, 0, 1);
    chk("haz2_req", 32'(inst_req), 32'h0);
    chk("haz2_over", 32'(if_over), 32'h0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Redirect near the top of the address space, then wrap
    cyc(1, 1, 32'hFFFF_FFF8, 0);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("hold_over", 32'(if_over), 32'h1);
    chk("hold_pc", if_pc, 32'h0000_0004);
    chk("req_queue_empty", 32'(exp_req.size()), 32'h0);
    chk("fire_queue_empty", 32'(exp_fire.size()), 32'h0);

    // Asynchronous reset mid-cycle with a buffered instruction
    #1 rst_n = 1'b0;
    #1 chk_zero_outputs("async_rst");
    @(negedge clk);
    exp_req  = '{32'h8000_0000, 32'h8000_0004};
    exp_fire = '{32'h8000_0000};
    rst_n = 1'b1; allow = 1'b1;
    #1 chk("reboot_req", 32'(inst_req), 32'h0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("restart_req_queue", 32'(exp_req.size()), 32'h0);
    chk("restart_fire_queue", 32'(exp_fire.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
